// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter in front of the register file.
// Each requester owns one holding slot; one slot drains per cycle, oldest first,
// so same-register writes commit in the order they were accepted.
module regfile_write_arbiter #(
  parameter bit DROP_R0 = 1'b1,
  localparam int unsigned RegW    = 5,
  localparam int unsigned DataW   = 32,
  localparam int unsigned NumRegs = 32
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [RegW-1:0]    req0_reg,
  input  logic [DataW-1:0]   req0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [RegW-1:0]    req1_reg,
  input  logic [DataW-1:0]   req1_data,
  output logic               ctrl_writeEnable,
  output logic [RegW-1:0]    ctrl_writeReg,
  output logic [DataW-1:0]   data_writeReg,
  output logic [NumRegs-1:0] pending_mask
);

  localparam int unsigned NumSlots = 2;

  // older is set on the slot that has waited longer; both clear means equal age
  typedef struct packed {
    logic             valid;
    logic [RegW-1:0]  regAddr;
    logic [DataW-1:0] data;
    logic             older;
  } slotState;

  slotState            slotQ [NumSlots];
  slotState            slotD [NumSlots];
  logic                lastGrantQ;
  logic                lastGrantD;
  logic [NumSlots-1:0] reqValid;
  logic [NumSlots-1:0] reqReady;
  logic [NumSlots-1:0] grant;
  logic [NumSlots-1:0] load;
  logic [RegW-1:0]     reqReg  [NumSlots];
  logic [DataW-1:0]    reqData [NumSlots];

  assign reqValid   = {req1_valid, req0_valid};
  assign reqReg[0]  = req0_reg;
  assign reqReg[1]  = req1_reg;
  assign reqData[0] = req0_data;
  assign reqData[1] = req1_data;
  assign req0_ready = reqReady[0];
  assign req1_ready = reqReady[1];

  // Pick one valid slot: sole valid slot, else older slot, else alternate on last grant
  always_comb begin
    grant = '0;
    if (!ctrl_reset) begin
      if (slotQ[0].valid && slotQ[1].valid) begin
        if (slotQ[0].older != slotQ[1].older) begin
          grant = slotQ[0].older ? 2'b01 : 2'b10;
        end else begin
          grant = lastGrantQ ? 2'b01 : 2'b10;
        end
      end else if (slotQ[0].valid) begin
        grant = 2'b01;
      end else if (slotQ[1].valid) begin
        grant = 2'b10;
      end
    end
  end

  // Ready when the slot is empty or draining this cycle; r0 writes are accepted but not loaded
  always_comb begin
    reqReady = '0;
    load     = '0;
    for (int i = 0; i < NumSlots; i++) begin
      reqReady[i] = !ctrl_reset && (!slotQ[i].valid || grant[i]);
      load[i]     = reqValid[i] && !ctrl_reset && (!slotQ[i].valid || grant[i])
                    && !(DROP_R0 && (reqReg[i] == '0));
    end
  end

  // Next slot contents, relative age and last-grant pointer
  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      slotD[i] = slotQ[i];
    end
    lastGrantD = lastGrantQ;

    for (int i = 0; i < NumSlots; i++) begin
      if (load[i]) begin
        slotD[i].valid   = 1'b1;
        slotD[i].regAddr = reqReg[i];
        slotD[i].data    = reqData[i];
      end else if (grant[i]) begin
        slotD[i].valid = 1'b0;
      end
    end

    if (|grant) begin
      lastGrantD = grant[1];
    end

    if (slotD[0].valid && slotD[1].valid) begin
      case (load)
        2'b01: begin
          slotD[0].older = 1'b0;
          slotD[1].older = 1'b1;
        end
        2'b10: begin
          slotD[0].older = 1'b1;
          slotD[1].older = 1'b0;
        end
        2'b11: begin
          slotD[0].older = 1'b0;
          slotD[1].older = 1'b0;
        end
        default: begin
        end
      endcase
    end else begin
      slotD[0].older = 1'b0;
      slotD[1].older = 1'b0;
    end
  end

  // Slot and arbitration state register
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NumSlots; i++) begin
        slotQ[i] <= '0;
      end
      lastGrantQ <= 1'b1;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        slotQ[i] <= slotD[i];
      end
      lastGrantQ <= lastGrantD;
    end
  end

  // Regfile write port driven straight from the granted slot
  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (grant[i]) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = slotQ[i].regAddr;
        data_writeReg    = slotQ[i].data;
      end
    end
  end

  // One-hot destinations of every held write
  always_comb begin
    pending_mask = '0;
    if (!ctrl_reset) begin
      for (int i = 0; i < NumSlots; i++) begin
        if (slotQ[i].valid) begin
          pending_mask[slotQ[i].regAddr] = 1'b1;
        end
      end
    end
    if (DROP_R0) begin
      pending_mask[0] = 1'b0;
    end
  end

endmodule
